// File: rtl/dct_feeder.sv
// Captures filterbank frames into a ping-pong buffer and replays each element held for REPEAT cycles toward the DCT.
// Latency: first valid_o one cycle after the completing edge. No input backpressure; input to a busy bank is dropped and flagged.
module dct_feeder #(
  parameter int I_BW      = 8,
  parameter int FRAME_LEN = 32,
  parameter int REPEAT    = 13,
  parameter int GAP       = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic [I_BW-1:0] data_i,
  input  logic            valid_i,
  input  logic            last_i,
  output logic [I_BW-1:0] data_o,
  output logic            valid_o,
  output logic            last_o,
  output logic            overflow_o,
  output logic            frame_err_o
);

  localparam int AW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int RW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [AW-1:0] ELEM_LAST = AW'(FRAME_LEN - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   elem_q, elem_d;
  logic [RW-1:0]   rep_q, rep_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            rbank_q, rbank_d;

  logic            wbank_q;
  logic [AW-1:0]   windex_q;
  logic [1:0]      full_q, full_d;
  logic [I_BW-1:0] mem [2*FRAME_LEN];

  logic            free_now, wfull, wr_en, at_end, complete, ferr, ovf, ready;
  logic            valid_d, last_d;
  logic [I_BW-1:0] data_d;

  // A bank being released by the reader on this edge is already writable.
  assign free_now = (state_q == S_PLAY) && (elem_q == ELEM_LAST) && (rep_q == REP_LAST);
  assign wfull    = full_q[wbank_q] && !(free_now && (rbank_q == wbank_q));
  assign wr_en    = valid_i && !wfull;
  assign at_end   = (windex_q == ELEM_LAST);
  assign complete = wr_en && last_i && at_end;
  assign ferr     = wr_en && (last_i != at_end);
  assign ovf      = valid_i && wfull;
  // Frame finishing on this edge counts so replay starts the very next cycle.
  assign ready    = full_q[rbank_q] || (complete && (wbank_q == rbank_q));

  always_comb begin
    full_d = full_q;
    if (free_now) full_d[rbank_q] = 1'b0;
    if (complete) full_d[wbank_q] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (en_i && wr_en) mem[{wbank_q, windex_q}] <= data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wbank_q  <= 1'b0;
      windex_q <= '0;
      full_q   <= '0;
    end else if (!en_i) begin
      wbank_q  <= 1'b0;
      windex_q <= '0;
      full_q   <= '0;
    end else begin
      full_q <= full_d;
      if (complete) begin
        wbank_q  <= ~wbank_q;
        windex_q <= '0;
      end else if (ferr) begin
        windex_q <= '0;
      end else if (wr_en) begin
        windex_q <= windex_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      elem_q  <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      rbank_q <= 1'b0;
    end else if (!en_i) begin
      state_q <= S_IDLE;
      elem_q  <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      rbank_q <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      rbank_q <= rbank_d;
    end
  end

  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    rbank_d = rbank_q;
    case (state_q)
      S_IDLE: begin
        if (ready) begin
          state_d = S_PLAY;
          elem_d  = '0;
          rep_d   = '0;
        end
      end
      S_PLAY: begin
        if (rep_q == REP_LAST) begin
          rep_d = '0;
          if (elem_q == ELEM_LAST) begin
            elem_d  = '0;
            rbank_d = ~rbank_q;
            gap_d   = '0;
            state_d = S_GAP;
          end else begin
            elem_d = elem_q + 1'b1;
          end
        end else begin
          rep_d = rep_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ready ? S_PLAY : S_IDLE;
          elem_d  = '0;
          rep_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are derived from next-state so the registered copies line up with the FSM.
  always_comb begin
    valid_d = (state_d == S_PLAY);
    last_d  = valid_d && (elem_d == ELEM_LAST);
    data_d  = valid_d ? mem[{rbank_d, elem_d}] : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_o      <= '0;
      valid_o     <= 1'b0;
      last_o      <= 1'b0;
      overflow_o  <= 1'b0;
      frame_err_o <= 1'b0;
    end else if (!en_i) begin
      data_o      <= '0;
      valid_o     <= 1'b0;
      last_o      <= 1'b0;
      overflow_o  <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      data_o      <= data_d;
      valid_o     <= valid_d;
      last_o      <= last_d;
      overflow_o  <= ovf;
      frame_err_o <= ferr;
    end
  end

endmodule
